// File: rtl/ir_receiver_bus.sv
// Bus-mapped IR frame receiver: synchronises and measures IR marks/spaces, decodes a frame into DATA/STATUS.
// Optional glitch filter on the synchronised input: define IR_RX_GLITCH_FILTER_EN.
module ir_receiver_bus #(
  parameter logic [7:0] BASE_ADDR     = 8'hA0,
  parameter int         FRAME_BITS    = 4,
  parameter int         CNT_W         = 18,
  parameter int         START_MIN     = 90000,
  parameter int         BIT0_MIN      = 12500,
  parameter int         BIT1_MIN      = 37500,
  parameter int         GAP_MAX       = 50000,
  parameter bit         IR_ACTIVE_LOW = 1'b1,
  parameter int         FILTER_CYC    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ir_in,
  input  logic [7:0] i_bus_addr,
  inout  wire  [7:0] io_bus_data,
  input  logic       i_bus_we,
  output logic       o_bus_interrupt_raise,
  input  logic       i_bus_interrupt_ack
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SPACE, S_MARK, S_DONE} state_t;

  localparam logic [CNT_W:0] C_START     = (CNT_W+1)'(START_MIN);
  localparam logic [CNT_W:0] C_BIT0      = (CNT_W+1)'(BIT0_MIN);
  localparam logic [CNT_W:0] C_BIT1      = (CNT_W+1)'(BIT1_MIN);
  localparam logic [CNT_W:0] C_GAP       = (CNT_W+1)'(GAP_MAX);
  localparam logic [2:0]     C_LAST      = 3'(FRAME_BITS-1);
  localparam logic [7:0]     C_DATA_ADDR = BASE_ADDR;
  localparam logic [7:0]     C_STAT_ADDR = BASE_ADDR + 8'd1;

  state_t           r_state, w_state_next;
  logic [1:0]       r_sync;
  logic             w_sync_mark, w_mark, r_mark_d, w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_len;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift, r_data, w_status, w_clr;
  logic             r_valid, r_ovr, r_err, r_raise, r_oe, r_rd_stat;
  logic             w_shift_en, w_restart, w_err_set, w_done, w_busy, w_rd_data_clr;
  logic             w_unused_bits;

  // Idle line level is loaded on reset so release never looks like a mark.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {2{IR_ACTIVE_LOW}};
    else          r_sync <= {r_sync[0], i_ir_in};
  end
  assign w_sync_mark = r_sync[1] ^ IR_ACTIVE_LOW;

`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int C_FCNT_W = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
  logic                r_filt;
  logic [C_FCNT_W-1:0] r_fcnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (w_sync_mark == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == C_FCNT_W'(FILTER_CYC-1)) begin
      r_filt <= w_sync_mark;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + C_FCNT_W'(1);
    end
  end
  assign w_mark = r_filt;
`else
  assign w_mark = w_sync_mark;
`endif

  assign w_edge = w_mark ^ r_mark_d;
  // w_len is the length of the run that is ending (or ongoing) including the current cycle.
  assign w_len  = {1'b0, r_cnt} + (CNT_W+1)'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mark_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mark_d <= w_mark;
      if (w_edge)           r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_restart    = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_mark) w_state_next = S_START;
      S_START: if (!w_mark) begin
        if (w_len >= C_START) begin
          w_state_next = S_SPACE;
          w_restart    = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SPACE: if (w_mark) begin
        w_state_next = S_MARK;
      end else if (w_len > C_GAP) begin
        w_state_next = S_IDLE;
        w_err_set    = 1'b1;
      end
      // A start-length mark inside a frame restarts it rather than decoding a bit.
      S_MARK:  if (!w_mark) begin
        if (w_len >= C_START) begin
          w_state_next = S_SPACE;
          w_restart    = 1'b1;
        end else if (w_len < C_BIT0) begin
          w_state_next = S_IDLE;
          w_err_set    = 1'b1;
        end else begin
          w_shift_en   = 1'b1;
          w_state_next = (r_bit_cnt == C_LAST) ? S_DONE : S_SPACE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_restart) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift[r_bit_cnt] <= (w_len >= C_BIT1);
      r_bit_cnt          <= r_bit_cnt + 3'd1;
    end
  end

  assign w_done        = (r_state == S_DONE);
  assign w_busy        = (r_state != S_IDLE);
  assign w_rd_data_clr = r_oe & ~r_rd_stat;
  assign w_clr         = (i_bus_we && i_bus_addr == C_STAT_ADDR) ? io_bus_data : 8'h00;
  assign w_unused_bits = ^{w_clr[7:4], w_clr[2]};
  assign w_status      = {4'b0000, r_err, w_busy, r_ovr, r_valid};

  // A frame completing in the same cycle as a DATA read takes priority over the read clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
      r_raise   <= 1'b0;
      r_oe      <= 1'b0;
      r_rd_stat <= 1'b0;
    end else begin
      r_oe      <= ~i_bus_we && (i_bus_addr == C_DATA_ADDR || i_bus_addr == C_STAT_ADDR);
      r_rd_stat <= (i_bus_addr == C_STAT_ADDR);
      if (w_done) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_rd_data_clr || w_clr[0]) begin
        r_valid <= 1'b0;
      end
      if (w_done && r_valid && !w_rd_data_clr) r_ovr <= 1'b1;
      else if (w_clr[1])                       r_ovr <= 1'b0;
      if (w_err_set)     r_err <= 1'b1;
      else if (w_clr[3]) r_err <= 1'b0;
      if (w_done)                   r_raise <= 1'b1;
      else if (i_bus_interrupt_ack) r_raise <= 1'b0;
    end
  end

  assign io_bus_data           = r_oe ? (r_rd_stat ? w_status : r_data) : 8'bzzzz_zzzz;
  assign o_bus_interrupt_raise = r_raise;

endmodule

// File: tb/tb_ir_receiver_bus.sv
// Randomised self-checking bench for ir_receiver_bus against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_ir_receiver_bus;
  localparam logic [7:0] BASE       = 8'hA0;
  localparam logic [7:0] IDLE_ADDR  = 8'h00;
  localparam int         START_MIN  = 20;
  localparam int         BIT0_MIN   = 4;
  localparam int         BIT1_MIN   = 10;
  localparam int         GAP_MAX    = 12;
  localparam int         FRAME_BITS = 4;
`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int         FILTER_CYC = 3;
`else
  localparam int         FILTER_CYC = 8;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, ir_in = 1'b1, we = 1'b0, ack = 1'b0;
  logic [7:0] addr = IDLE_ADDR;
  logic [7:0] tb_drv = 8'h00;
  logic       tb_drv_en = 1'b0;
  logic       raise;
  wire  [7:0] bus_data;

  assign bus_data = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pu
      pullup (bus_data[gi]);
    end
  endgenerate

  ir_receiver_bus #(
    .BASE_ADDR(BASE), .FRAME_BITS(FRAME_BITS), .CNT_W(18), .START_MIN(START_MIN),
    .BIT0_MIN(BIT0_MIN), .BIT1_MIN(BIT1_MIN), .GAP_MAX(GAP_MAX), .IR_ACTIVE_LOW(1'b1),
    .FILTER_CYC(FILTER_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir_in(ir_in), .i_bus_addr(addr), .io_bus_data(bus_data),
    .i_bus_we(we), .o_bus_interrupt_raise(raise), .i_bus_interrupt_ack(ack)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Behavioural model of the register file, updated per transaction.
  logic [7:0] m_data = 8'h00;
  bit m_valid = 0, m_ovr = 0, m_err = 0, m_raise = 0;
  bit m_chk = 0, rd_pending = 0;

  function automatic logic [7:0] m_status();
    return {4'b0000, m_err, 1'b0, m_ovr, m_valid};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus must float (pulled to ff) except in the cycle after a read; raise tracks the model when settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!rd_pending && !tb_drv_en) begin
        checks++;
        if (bus_data !== 8'hff) begin
          errors++;
          $display("FAIL bus_idle: got %h, expected undriven (pulled ff)", bus_data);
        end
      end
      if (m_chk) begin
        checks++;
        if (raise !== m_raise) begin
          errors++;
          $display("FAIL raise_track: got %b, expected %b", raise, m_raise);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mark, input int n);
    ir_in = ~mark;
    if (n > 0) tick(n);
  endtask

  task automatic model_frame(input int st, input int nb, input int mk[8], input int sp[8]);
    logic [7:0] acc;
    acc = 8'h00;
    if (st < START_MIN) return;
    for (int i = 0; i < nb; i++) begin
      if (sp[i] > GAP_MAX || mk[i] < BIT0_MIN) begin
        m_err = 1;
        return;
      end
      if (mk[i] >= BIT1_MIN) acc = acc | (8'h01 << i);
    end
    if (nb == FRAME_BITS) begin
      m_ovr   = m_ovr | m_valid;
      m_valid = 1;
      m_data  = acc;
      m_raise = 1;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic send_frame(input int st, input int nb, input int mk[8], input int sp[8],
                            input int tail, input bit spikes);
    m_chk = 0;
    drive(1, st);
    for (int i = 0; i < nb; i++) begin
      if (spikes) begin
        drive(0, sp[i] / 2);
        drive(1, 1);
        drive(0, sp[i] - sp[i] / 2 - 1);
      end else begin
        drive(0, sp[i]);
      end
      drive(1, mk[i]);
    end
    drive(0, tail + 12);
    model_frame(st, nb, mk, sp);
    m_chk = 1;
    $display("frame start=%0d bits=%0d marks=%0d,%0d,%0d,%0d -> model data=%h status=%h",
             st, nb, mk[0], mk[1], mk[2], mk[3], m_data, m_status());
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    we   = 0;
    @(posedge clk);
    #1;
    addr       = IDLE_ADDR;
    rd_pending = 1;
    @(negedge clk);
    d = bus_data;
    @(posedge clk);
    #1;
    rd_pending = 0;
  endtask

  task automatic read_data_chk(input string name);
    logic [7:0] d;
    bus_read(BASE, d);
    check(name, d, m_data);
    m_valid = 0;
    $display("read DATA -> %h", d);
  endtask

  task automatic read_stat_chk(input string name);
    logic [7:0] d;
    bus_read(BASE + 8'd1, d);
    check(name, d, m_status());
    $display("read STATUS -> %h", d);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
    addr      = a;
    we        = 1;
    tb_drv    = v;
    tb_drv_en = 1;
    @(posedge clk);
    #1;
    we        = 0;
    tb_drv_en = 0;
    addr      = IDLE_ADDR;
    if (a == BASE + 8'd1) begin
      if (v[0]) m_valid = 0;
      if (v[1]) m_ovr = 0;
      if (v[3]) m_err = 0;
    end
    $display("write %h <- %h", a, v);
  endtask

  task automatic do_ack();
    m_chk = 0;
    ack   = 1;
    @(negedge clk);
    check("raise_in_ack_cycle", {7'd0, raise}, {7'd0, m_raise});
    @(posedge clk);
    #1;
    ack = 0;
    @(negedge clk);
    check("raise_after_ack", {7'd0, raise}, 8'h00);
    m_raise = 0;
    m_chk   = 1;
    $display("ack -> raise=%b", raise);
  endtask

  function automatic void make_frame(input logic [3:0] v, output int mk[8], output int sp[8]);
    for (int i = 0; i < 8; i++) begin
      mk[i] = (i < 4 && v[i]) ? 12 : 5;
      sp[i] = 6;
    end
  endfunction

  initial begin
    int mk[8], sp[8];
    int st, act;
    logic [3:0] v;
    logic [7:0] d;

    // Reset state
    tick(3);
    check("reset_raise", {7'd0, raise}, 8'h00);
    check("reset_bus", bus_data, 8'hff);
    rst_n = 1;
    tick(3);
    m_chk = 1;
    read_stat_chk("reset_status");
    read_data_chk("reset_data");

    // 1: frame 9
    make_frame(4'h9, mk, sp);
    send_frame(25, 4, mk, sp, 6, 0);
    check("model_pin_t1", m_data, 8'h09);
    check("t1_raise", {7'd0, raise}, 8'h01);
    bus_read(BASE + 8'd1, d);
    check("t1_status_lit", d, 8'h01);
    do_ack();

    // 2: read DATA, VALID cleared
    bus_read(BASE, d);
    check("t2_data_lit", d, 8'h09);
    m_valid = 0;
    read_stat_chk("t2_status");

    // 3: two frames, overrun, W1C
    send_frame(25, 4, mk, sp, 6, 0);
    make_frame(4'h6, mk, sp);
    send_frame(25, 4, mk, sp, 6, 0);
    bus_read(BASE + 8'd1, d);
    check("t3_status_lit", d, 8'h03);
    bus_write(BASE + 8'd1, 8'h02);
    read_stat_chk("t3_status_w1c");
    bus_write(BASE, 8'hff);
    read_data_chk("t3_data");
    check("model_pin_t3", m_data, 8'h06);
    do_ack();

    // 4: gap abort, then noise mark
    send_frame(25, 1, mk, sp, 15, 0);
    bus_read(BASE + 8'd1, d);
    check("t4_status_lit", d, 8'h08);
    send_frame(2, 0, mk, sp, 0, 0);
    read_stat_chk("t4_noise_status");
    bus_write(BASE + 8'd1, 8'h08);
    read_stat_chk("t4_cleared");

    // 5: reset during bit 3, then clean frame
    m_chk = 0;
    make_frame(4'h9, mk, sp);
    drive(1, 25);
    for (int i = 0; i < 3; i++) begin
      drive(0, 6);
      drive(1, mk[i]);
    end
    drive(0, 6);
    drive(1, 6);
    rst_n = 0;
    #1;
    check("t5_rst_raise", {7'd0, raise}, 8'h00);
    check("t5_rst_bus", bus_data, 8'hff);
    tick(3);
    ir_in = 1;
    tick(2);
    rst_n = 1;
    m_data = 8'h00; m_valid = 0; m_ovr = 0; m_err = 0; m_raise = 0;
    tick(4);
    m_chk = 1;
    read_stat_chk("t5_status_after_rst");
    read_data_chk("t5_data_after_rst");
    make_frame(4'h6, mk, sp);
    send_frame(25, 4, mk, sp, 6, 0);
    read_data_chk("t5_data_frame");
    do_ack();

`ifdef IR_RX_GLITCH_FILTER_EN
    // 6: spikes in spaces are filtered out
    make_frame(4'h9, mk, sp);
    send_frame(25, 4, mk, sp, 6, 1);
    bus_read(BASE, d);
    check("t6_spiky_data_lit", d, 8'h09);
    m_valid = 0;
    do_ack();
`endif

    // Randomised frames and bus activity
    for (int n = 0; n < 25; n++) begin
      v  = 4'($urandom_range(0, 15));
      st = $urandom_range(21, 30);
      for (int i = 0; i < 8; i++) begin
        mk[i] = (i < 4 && v[i]) ? $urandom_range(11, 16) : $urandom_range(5, 8);
        sp[i] = $urandom_range(3, 9);
      end
      if ($urandom_range(0, 5) == 0) sp[$urandom_range(0, 3)] = $urandom_range(16, 20);
      else if ($urandom_range(0, 5) == 0) mk[$urandom_range(0, 3)] = 3;
      send_frame(st, 4, mk, sp, 6, 0);
      act = $urandom_range(0, 3);
      case (act)
        0: read_data_chk("rnd_data");
        1: read_stat_chk("rnd_status");
        2: begin
          bus_write(BASE + 8'd1, {4'h0, 4'($urandom_range(0, 15))});
          read_stat_chk("rnd_w1c_status");
        end
        default: do_ack();
      endcase
    end
    read_stat_chk("final_status");
    read_data_chk("final_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
